// File: rtl/umem_arb.sv
// ---------------------------------------------------------------------------
// umem_arb
//
// Arbiter that shares a single unified memory between instruction fetch and
// MEM-stage data accesses of a pipelined core. Each instruction goes through
// IDLE -> (DATA) -> FETCH -> ADV. The pipeline is held (StallPipe=1) in
// every state except ADV, which lasts one cycle and lets every stage
// register advance.
//
// Optional feature macro: UMEM_ARB_TIMEOUT_EN
//   defined   : an 8-bit wait counter aborts an access that has waited too
//               long, substitutes a safe value and sets the sticky MemFault.
//   undefined : accesses wait indefinitely, MemFault is tied to 0.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   MemWriteM    MEM-stage store flag
//   ResultSrcM   MEM-stage result select, 2'b01 marks a load
//   ALUResultM   MEM-stage data address
//   WriteDataM   MEM-stage store data
//   PCF          fetch address
//   mem_ready    memory completes the current access this cycle
//   mem_rdata    memory read data, valid with mem_ready
//   mem_req      access request to the unified memory
//   mem_we       write enable
//   mem_addr     access address
//   mem_wdata    write data
//   InstrF       registered fetched instruction
//   ReadDataM    registered load data
//   StallPipe    1 = all pipeline stage registers hold
//   MemFault     sticky access-timeout flag
// ---------------------------------------------------------------------------
module umem_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCF,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [31:0] InstrF,
   output logic [31:0] ReadDataM,
   output logic        StallPipe,
   output logic        MemFault
);

   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2,
      ADV   = 2'd3
   } state_t;

   state_t state;
   state_t state_next;
   logic   data_req;
   logic   timeout;

   assign data_req = MemWriteM | (ResultSrcM == 2'b01);

`ifdef UMEM_ARB_TIMEOUT_EN
   logic [7:0] wait_count;
   logic       in_access;
   logic       fault;

   assign in_access = (state == DATA) || (state == FETCH);

   // The access gives up on the cycle in which the wait counter would
   // reach 255, so the abandoned access leaves its state on that edge.
   assign timeout = in_access && !mem_ready && (wait_count == 8'd254);

   // Wait counter: restarts whenever a new access (DATA or FETCH) is
   // entered, and counts cycles the memory has not answered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_count <= 8'd0;
      end else if ((state_next != state) &&
                   ((state_next == DATA) || (state_next == FETCH))) begin
         wait_count <= 8'd0;
      end else if (in_access && !mem_ready) begin
         wait_count <= wait_count + 8'd1;
      end
   end

   // Sticky fault flag, only cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault <= 1'b0;
      end else if (timeout) begin
         fault <= 1'b1;
      end
   end

   assign MemFault = fault;
`else
   assign timeout  = 1'b0;
   assign MemFault = 1'b0;
`endif

   // State register. Because the memory request is decoded from this
   // register alone, reset drops mem_req immediately, without a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and memory-port decode. Address and data come straight from
   // the stage inputs; they stay stable while waiting because the pipeline
   // is stalled for the whole access.
   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      StallPipe  = 1'b1;
      case (state)
         IDLE: begin
            state_next = data_req ? DATA : FETCH;
         end
         DATA: begin
            mem_req   = 1'b1;
            mem_we    = MemWriteM;
            mem_addr  = ALUResultM;
            mem_wdata = WriteDataM;
            if (mem_ready || timeout) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = PCF;
            if (mem_ready || timeout) begin
               state_next = ADV;
            end
         end
         ADV: begin
            StallPipe  = 1'b0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Capture registers for fetched instruction and load data. A load is a
   // data access without the store flag. An aborted fetch yields a NOP and
   // an aborted data access yields zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         InstrF    <= NOP;
         ReadDataM <= 32'h0;
      end else begin
         if (state == DATA) begin
            if (mem_ready) begin
               if (!MemWriteM) begin
                  ReadDataM <= mem_rdata;
               end
            end else if (timeout) begin
               ReadDataM <= 32'h0;
            end
         end
         if (state == FETCH) begin
            if (mem_ready) begin
               InstrF <= mem_rdata;
            end else if (timeout) begin
               InstrF <= NOP;
            end
         end
      end
   end

endmodule

// File: tb/tb_umem_arb.sv
// ---------------------------------------------------------------------------
// tb_umem_arb
//
// Self-checking bench for umem_arb. Each instruction is described at the
// transaction level (optional data access, then fetch, with a memory
// latency each); the bench expands it into the cycle-by-cycle trace the
// arbiter must produce and compares the memory port, stall and capture
// registers every cycle.
// ---------------------------------------------------------------------------
module tb_umem_arb;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        rst;
   logic        MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] PCF;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] InstrF;
   logic [31:0] ReadDataM;
   logic        StallPipe;
   logic        MemFault;

   int tests_run;
   int tests_failed;

   // Architectural expectations carried across instructions.
   logic [31:0] exp_instr;
   logic [31:0] exp_rdm;
   logic        exp_fault;

   typedef struct {
      logic         rdy;
      logic [31:0]  rd;
      logic [131:0] exp;
   } cyc_t;

   umem_arb dut (
      .clk        (clk),
      .rst        (rst),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCF        (PCF),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .InstrF     (InstrF),
      .ReadDataM  (ReadDataM),
      .StallPipe  (StallPipe),
      .MemFault   (MemFault)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Runs one instruction starting in the IDLE cycle (called just after a
   // rising edge). Expected trace: one idle cycle, dlat+1 data cycles when
   // a data access exists, flat+1 fetch cycles, one advance cycle.
   task automatic run_instr(input string name, input logic is_store, input logic is_load,
                            input logic [31:0] daddr, input logic [31:0] wdat,
                            input logic [31:0] pc, input int dlat, input int flat,
                            input logic [31:0] drd, input logic [31:0] frd);
      cyc_t         q[$];
      cyc_t         c;
      logic [131:0] got;
      MemWriteM  = is_store;
      ResultSrcM = is_load ? 2'b01 : (($urandom % 2) != 0 ? 2'b10 : 2'b00);
      ALUResultM = daddr;
      WriteDataM = wdat;
      PCF        = pc;
      c.rdy = 1'($urandom);
      c.rd  = $urandom;
      c.exp = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, exp_instr, exp_rdm, exp_fault};
      q.push_back(c);
      if (is_store || is_load) begin
         for (int k = 0; k <= dlat; k++) begin
            c.rdy = (k == dlat);
            c.rd  = (k == dlat) ? drd : $urandom;
            c.exp = {1'b1, is_store, daddr, wdat, 1'b1, exp_instr, exp_rdm, exp_fault};
            q.push_back(c);
         end
         if (is_load) exp_rdm = drd;
      end
      for (int k = 0; k <= flat; k++) begin
         c.rdy = (k == flat);
         c.rd  = (k == flat) ? frd : $urandom;
         c.exp = {1'b1, 1'b0, pc, 32'h0, 1'b1, exp_instr, exp_rdm, exp_fault};
         q.push_back(c);
      end
      exp_instr = frd;
      c.rdy = 1'($urandom);
      c.rd  = $urandom;
      c.exp = {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, exp_instr, exp_rdm, exp_fault};
      q.push_back(c);
      for (int i = 0; i < q.size(); i++) begin
         mem_ready = q[i].rdy;
         mem_rdata = q[i].rd;
         @(negedge clk);
         got = {mem_req, mem_we, mem_addr, mem_wdata, StallPipe, InstrF, ReadDataM, MemFault};
         tests_run++;
         if (got !== q[i].exp) begin
            tests_failed++;
            $display("[TB] FAIL %s cycle %0d: got %h required %h", name, i, got, q[i].exp);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Reset values, then release so the next cycle is IDLE.
   task automatic test_reset;
      logic [131:0] got;
      logic [131:0] want;
      rst        = 1'b1;
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      ALUResultM = 32'h0;
      WriteDataM = 32'h0;
      PCF        = 32'h0;
      mem_ready  = 1'b0;
      mem_rdata  = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      got  = {mem_req, mem_we, mem_addr, mem_wdata, StallPipe, InstrF, ReadDataM, MemFault};
      want = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, NOP, 32'h0, 1'b0};
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL reset_values: got %h required %h", got, want);
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      exp_instr = NOP;
      exp_rdm   = 32'h0;
      exp_fault = 1'b0;
   endtask

   // Zero-wait fetch-only stream: 3-cycle period.
   task automatic test_fetch_stream;
      for (int i = 0; i < 3; i++) begin
         run_instr("fetch_stream", 1'b0, 1'b0, 32'h0, 32'h0, 32'h100 + 32'(4 * i), 0, 0,
                   32'h0, 32'h00500093);
      end
   endtask

   // Load then fetch, zero wait: 4-cycle period.
   task automatic test_load;
      run_instr("load", 1'b0, 1'b1, 32'h2000, 32'h0, 32'h104, 0, 0,
                32'hDEADBEEF, 32'h00A00113);
   endtask

   // Store with a three-cycle memory delay; outputs must hold steady and
   // ReadDataM must not change.
   task automatic test_store;
      run_instr("store", 1'b1, 1'b0, 32'h2004, 32'h12345678, 32'h108, 3, 1,
                32'hA5A5A5A5, 32'h00B00193);
   endtask

   // Random mix of instruction kinds and memory latencies.
   task automatic test_random;
      int kind;
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 2));
         run_instr("random", kind == 2, kind == 1, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   $urandom, $urandom);
      end
   endtask

   // Reset asserted between edges during a waiting fetch.
   task automatic test_reset_mid_fetch;
      logic [98:0] got;
      logic [98:0] want;
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      PCF        = 32'h200;
      mem_ready  = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      tests_run++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin
         tests_failed++;
         $display("[TB] FAIL midfetch_enter: got %h required %h", {mem_req, mem_addr}, {1'b1, 32'h200});
      end
      #2;
      rst = 1'b1;
      #1;
      got  = {mem_req, StallPipe, InstrF, ReadDataM, MemFault};
      want = {1'b0, 1'b1, NOP, 32'h0, 1'b0};
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL midfetch_reset: got %h required %h", got, want);
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      exp_instr = NOP;
      exp_rdm   = 32'h0;
      exp_fault = 1'b0;
      run_instr("after_reset", 1'b0, 1'b1, 32'h40, 32'h0, 32'h204, 1, 0,
                32'h0BADF00D, 32'h00100073);
   endtask

   // Memory that never answers a fetch.
   task automatic test_timeout;
      int n;
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      PCF        = 32'h300;
      mem_ready  = 1'b0;
      @(posedge clk);
      #1;
`ifdef UMEM_ARB_TIMEOUT_EN
      n = 0;
      while (mem_req === 1'b1 && n < 2000) begin
         mem_rdata = $urandom;
         @(posedge clk);
         #1;
         n++;
      end
      tests_run++;
      if (n !== 255) begin
         tests_failed++;
         $display("[TB] FAIL timeout_len: got %0d required %0d", n, 255);
      end
      @(negedge clk);
      tests_run++;
      if ({mem_req, StallPipe, InstrF, MemFault} !== {1'b0, 1'b0, NOP, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL timeout_adv: got %h required %h",
                  {mem_req, StallPipe, InstrF, MemFault}, {1'b0, 1'b0, NOP, 1'b1});
      end
      @(posedge clk);
      #1;
      exp_instr = NOP;
      exp_fault = 1'b1;
      run_instr("fault_sticky", 1'b0, 1'b0, 32'h0, 32'h0, 32'h304, 0, 0, 32'h0, 32'h00200093);
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (MemFault !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL fault_clear: got %b required %b", MemFault, 1'b0);
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      exp_instr = NOP;
      exp_rdm   = 32'h0;
      exp_fault = 1'b0;
`else
      n = 0;
      repeat (1000) begin
         mem_rdata = $urandom;
         @(posedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      tests_run++;
      if ({mem_req, mem_addr, StallPipe, MemFault} !== {1'b1, 32'h300, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL no_timeout_wait after %0d cycles: got %h required %h", n,
                  {mem_req, mem_addr, StallPipe, MemFault}, {1'b1, 32'h300, 1'b1, 1'b0});
      end
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFE0013;
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({mem_req, StallPipe, InstrF, MemFault} !== {1'b0, 1'b0, 32'hCAFE0013, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL no_timeout_done: got %h required %h",
                  {mem_req, StallPipe, InstrF, MemFault}, {1'b0, 1'b0, 32'hCAFE0013, 1'b0});
      end
      @(posedge clk);
      #1;
      exp_instr = 32'hCAFE0013;
`endif
      run_instr("after_timeout", 1'b1, 1'b0, 32'h80, 32'h55AA55AA, 32'h308, 2, 2,
                32'h0, 32'h00300093);
   endtask

   // Scenario sequence and summary.
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      exp_instr    = NOP;
      exp_rdm      = 32'h0;
      exp_fault    = 1'b0;
      rst          = 1'b1;
      test_reset;
      test_fetch_stream;
      test_load;
      test_store;
      test_random;
      test_reset_mid_fetch;
      test_timeout;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
